// File: rtl/des_moore.sv
// Serial-bit Moore sequence detector: the state is the matched-prefix length k,
// and y is high while k equals the full pattern length.
module des_moore #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1001,
    parameter bit                     OVERLAP     = 1'b1
) (
    output logic y,
    input  logic in,
    input  logic rst,
    input  logic clk
);

    localparam int              SW    = $clog2(PATTERN_LEN + 1);
    localparam int              NENC  = 2 ** SW;
    localparam logic [SW-1:0]   K_MAX = SW'(PATTERN_LEN);

    // Bit i of the pattern in arrival order (i = 0 is received first).
    function automatic logic pat_bit(input int i);
        logic [PATTERN_LEN-1:0] t;
        t = PATTERN >> (PATTERN_LEN - 1 - i);
        return t[0];
    endfunction

    // Longest pattern prefix that is a suffix of (first k pattern bits, b).
    // A length of k+1 is the plain "bit matched" advance.
    function automatic int next_k(input int k, input logic b);
        int   best;
        int   j;
        logic ok;
        logic sb;
        if (k == PATTERN_LEN && !OVERLAP)
            return (b == pat_bit(0)) ? 1 : 0;
        best = 0;
        for (int len = 1; len <= PATTERN_LEN; len++) begin
            if (len <= k + 1) begin
                ok = 1'b1;
                for (int i = 0; i < len; i++) begin
                    j = k + 1 - len + i;
                    if (j == k)
                        sb = b;
                    else
                        sb = pat_bit(j);
                    if (sb != pat_bit(i))
                        ok = 1'b0;
                end
                if (ok)
                    best = len;
            end
        end
        return best;
    endfunction

    logic [SW-1:0] state;
    logic [SW-1:0] state_nxt;
    logic [SW-1:0] nxt_one  [NENC];
    logic [SW-1:0] nxt_zero [NENC];

    // Transition table resolved at elaboration; unused encodings fall back to S0.
    for (genvar k = 0; k < NENC; k++) begin : g_nxt
        if (k <= PATTERN_LEN) begin : g_used
            assign nxt_one[k]  = SW'(next_k(k, 1'b1));
            assign nxt_zero[k] = SW'(next_k(k, 1'b0));
        end else begin : g_unused
            assign nxt_one[k]  = '0;
            assign nxt_zero[k] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= '0;
        else
            state <= state_nxt;
    end

    // A non-1 input (including X/Z in simulation) takes the 0 branch.
    always_comb begin
        state_nxt = '0;
        if (in)
            state_nxt = nxt_one[state];
        else
            state_nxt = nxt_zero[state];
    end

    always_comb begin
        y = 1'b0;
        y = (state == K_MAX);
    end

endmodule

// File: tb/tb_des_moore.sv
// Directed bench for des_moore: default 1001 pattern with and without overlap,
// plus a 111 pattern exercising back-to-back detections.
module tb_des_moore;

    logic clk = 1'b0;
    logic rst;
    logic in_ab;
    logic in_c;
    logic y_a;
    logic y_b;
    logic y_c;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    des_moore dut_a (.y(y_a), .in(in_ab), .rst(rst), .clk(clk));

    des_moore #(.OVERLAP(1'b0)) dut_b (.y(y_b), .in(in_ab), .rst(rst), .clk(clk));

    des_moore #(.PATTERN_LEN(3), .PATTERN(3'b111), .OVERLAP(1'b1)) dut_c (
        .y(y_c), .in(in_c), .rst(rst), .clk(clk)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step_ab(input logic b);
        @(negedge clk);
        in_ab = b;
        @(posedge clk);
        #1;
    endtask

    task automatic step_c(input logic b);
        @(negedge clk);
        in_c = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        in_ab = 1'bx;
        in_c  = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_y_a", 8'(y_a), 8'd0);
        chk("rst_y_b", 8'(y_b), 8'd0);
        chk("rst_y_c", 8'(y_c), 8'd0);
        chk("rst_state_a", 8'(dut_a.state), 8'd0);

        // First post-reset edge with the input left undriven.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("x_in_y_a", 8'(y_a), 8'd0);
        chk("x_in_state_a", 8'(dut_a.state), 8'd0);

        // 1,0,0,1 -> first hit on the fourth bit.
        step_ab(1'b1); chk("b1_y_a", 8'(y_a), 8'd0); chk("b1_state_a", 8'(dut_a.state), 8'd1);
        step_ab(1'b0); chk("b2_y_a", 8'(y_a), 8'd0); chk("b2_state_a", 8'(dut_a.state), 8'd2);
        step_ab(1'b0); chk("b3_y_a", 8'(y_a), 8'd0); chk("b3_state_a", 8'(dut_a.state), 8'd3);
        step_ab(1'b1); chk("hit1_y_a", 8'(y_a), 8'd1); chk("hit1_y_b", 8'(y_b), 8'd1);

        // 0,0,1 -> overlapping second hit only when OVERLAP=1.
        step_ab(1'b0); chk("ov1_y_a", 8'(y_a), 8'd0); chk("ov1_state_a", 8'(dut_a.state), 8'd2);
        chk("ov1_state_b", 8'(dut_b.state), 8'd0);
        step_ab(1'b0); chk("ov2_y_a", 8'(y_a), 8'd0); chk("ov2_y_b", 8'(y_b), 8'd0);
        step_ab(1'b1); chk("hit2_y_a", 8'(y_a), 8'd1); chk("hit2_y_b", 8'(y_b), 8'd0);
        chk("hit2_state_b", 8'(dut_b.state), 8'd1);

        // 1,1 -> settles on the "1" prefix.
        step_ab(1'b1); chk("r1_y_a", 8'(y_a), 8'd0); chk("r1_state_a", 8'(dut_a.state), 8'd1);
        step_ab(1'b1); chk("r2_y_a", 8'(y_a), 8'd0); chk("r2_state_a", 8'(dut_a.state), 8'd1);
        chk("r2_state_b", 8'(dut_b.state), 8'd1);

        // Reset in the middle of 1,0,0 discards the partial match.
        step_ab(1'b1);
        step_ab(1'b0);
        chk("pre_rst_state_a", 8'(dut_a.state), 8'd2);
        @(negedge clk);
        in_ab = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_state_a", 8'(dut_a.state), 8'd0);
        chk("mid_rst_y_a", 8'(y_a), 8'd0);
        @(negedge clk);
        rst   = 1'b0;
        in_ab = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_y_a", 8'(y_a), 8'd0);
        chk("post_rst_y_b", 8'(y_b), 8'd0);
        chk("post_rst_state_a", 8'(dut_a.state), 8'd1);

        // 111 pattern: y on edges 3, 4 and 5 of a held 1.
        chk("c_idle_state", 8'(dut_c.state), 8'd0);
        step_c(1'b1); chk("c_e1_y", 8'(y_c), 8'd0);
        step_c(1'b1); chk("c_e2_y", 8'(y_c), 8'd0);
        step_c(1'b1); chk("c_e3_y", 8'(y_c), 8'd1);
        step_c(1'b1); chk("c_e4_y", 8'(y_c), 8'd1);
        step_c(1'b1); chk("c_e5_y", 8'(y_c), 8'd1);
        step_c(1'b0); chk("c_e6_y", 8'(y_c), 8'd0); chk("c_e6_state", 8'(dut_c.state), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
